// File: rtl/udp_tx_feeder.sv
// udp_tx_feeder: buffers 32-bit user words and feeds them to the UDP tx engine
// as packets. A packet is launched when PKT_WORDS words are buffered, or when
// a partial packet has sat idle for TIMEOUT cycles.
module udp_tx_feeder #(
    parameter int FIFO_DEPTH = 256,
    parameter int PKT_WORDS  = 64,
    parameter int TIMEOUT    = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        full,
    output logic [15:0] ovf_cnt,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [31:0] tx_data,
    input  logic        tx_done,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] n_words;
    logic [LW-1:0] sent;
    logic [TW-1:0] timer;

    logic          wr_ok;
    logic          pop;
    logic          load_n;
    logic [LW-1:0] n_load;

    assign full        = (level == LW'(FIFO_DEPTH));
    assign wr_ok       = wr_en && !full;
    // Only pop while the packet still owes words; extra requests are ignored.
    assign pop         = (state == SEND) && tx_req && (sent < n_words);
    assign tx_start_en = (state == START);
    assign busy        = (state != IDLE);

    // FIFO storage; no reset needed, occupancy is tracked by level.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and level; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Registered read data: the popped word is presented from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_data <= '0;
        else if (pop)
            tx_data <= mem[rd_ptr];
    end

    // Saturating count of writes dropped because the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt <= '0;
        else if (wr_en && full && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'd1;
    end

    // Idle timer: restarts on every accepted write and when a packet launches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (wr_ok || ((state == IDLE) && (state_nx != IDLE)))
            timer <= '0;
        else if (state == IDLE) begin
            if (level == '0)
                timer <= '0;
            else if (timer != TW'(TIMEOUT))
                timer <= timer + TW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; the full-packet test takes priority over the timeout.
    always_comb begin
        state_nx = state;
        load_n   = 1'b0;
        n_load   = level;
        case (state)
            IDLE: begin
                if (level >= LW'(PKT_WORDS)) begin
                    state_nx = START;
                    load_n   = 1'b1;
                    n_load   = LW'(PKT_WORDS);
                end else if ((level != '0) && (timer == TW'(TIMEOUT))) begin
                    state_nx = START;
                    load_n   = 1'b1;
                    n_load   = level;
                end
            end
            START:     state_nx = SEND;
            SEND: begin
                // An early tx_done abandons the rest; unsent words stay queued.
                if (tx_done)
                    state_nx = IDLE;
                else if (sent == n_words)
                    state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done)
                    state_nx = IDLE;
            end
            default:   state_nx = IDLE;
        endcase
    end

    // Packet length latch; byte count stays valid until the next launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_words     <= '0;
            tx_byte_num <= '0;
        end else if (load_n) begin
            n_words     <= n_load;
            tx_byte_num <= 16'({n_load, 2'b00});
        end
    end

    // Words handed to the engine in the current packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sent <= '0;
        else if (state == START)
            sent <= '0;
        else if (pop)
            sent <= sent + LW'(1);
    end

endmodule

// File: tb/tb_udp_tx_feeder.sv
// Directed bench for udp_tx_feeder (FIFO_DEPTH=16, PKT_WORDS=16, TIMEOUT=100).
// Inputs change and outputs are sampled on the falling edge.
module tb_udp_tx_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic [15:0] ovf_cnt;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req = 1'b0;
    logic [31:0] tx_data;
    logic        tx_done = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    udp_tx_feeder #(.FIFO_DEPTH(16), .PKT_WORDS(16), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .ovf_cnt(ovf_cnt), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] d);
        wr_en = 1'b1; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic done_pulse;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (tx_start_en === 1'b1) begin ok = 1'b1; break; end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL rst_ovf: got %0d want 0", ovf_cnt); end
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd0) begin errors++; $display("FAIL rst_bytes: got %0d want 0", tx_byte_num); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_full_packet;
        for (int i = 0; i < 16; i++) wr(32'hA000_0000 + 32'(i));
        // Level just reached PKT_WORDS; START registers on the next edge.
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL t1_early_start: got %b want 0", tx_start_en); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL t1_full: got %b want 1", full); end
        tick;
        checks++; if (tx_start_en !== 1'b1) begin errors++; $display("FAIL t1_start: got %b want 1", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd64) begin errors++; $display("FAIL t1_bytes: got %0d want 64", tx_byte_num); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy); end
        tick;
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL t1_start_pulse: got %b want 0", tx_start_en); end
        for (int i = 0; i < 16; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL t1_data[%0d]: got %h want %h", i, tx_data, 32'hA000_0000 + 32'(i));
            end
        end
        tx_req = 1'b0;
        tick; tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_wait_busy: got %b want 1", busy); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL t1_drained: got %b want 0", full); end
        done_pulse;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle: got %b want 0", busy); end
        checks++; if (tx_byte_num !== 16'd64) begin errors++; $display("FAIL t1_bytes_hold: got %0d want 64", tx_byte_num); end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 5; i++) wr(32'hB000_0000 + 32'(i));
        // Timer is 0 after the last write's edge and reaches 100 one hundred edges later.
        repeat (100) tick;
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL t2_early: got %b want 0", tx_start_en); end
        tick;
        checks++; if (tx_start_en !== 1'b1) begin errors++; $display("FAIL t2_start: got %b want 1", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd20) begin errors++; $display("FAIL t2_bytes: got %0d want 20", tx_byte_num); end
        tick;
        for (int i = 0; i < 5; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'hB000_0000 + 32'(i)) begin
                errors++; $display("FAIL t2_data[%0d]: got %h want %h", i, tx_data, 32'hB000_0000 + 32'(i));
            end
        end
        tx_req = 1'b0;
        tick; tick;
        done_pulse;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle: got %b want 0", busy); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 20; i++) begin
            wr(32'hC000_0000 + 32'(i));
            if (i == 14) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL t3_not_full: got %b want 0", full); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL t3_full: got %b want 1", full); end
            end
        end
        checks++; if (ovf_cnt !== 16'd4) begin errors++; $display("FAIL t3_ovf: got %0d want 4", ovf_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t3_busy: got %b want 1", busy); end
        for (int i = 0; i < 16; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'hC000_0000 + 32'(i)) begin
                errors++; $display("FAIL t3_data[%0d]: got %h want %h", i, tx_data, 32'hC000_0000 + 32'(i));
            end
        end
        tx_req = 1'b0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL t3_drained: got %b want 0", full); end
        tick; tick;
        done_pulse;
        checks++; if (ovf_cnt !== 16'd4) begin errors++; $display("FAIL t3_ovf_hold: got %0d want 4", ovf_cnt); end
    endtask

    task automatic test_concurrent;
        for (int i = 0; i < 16; i++) wr(32'hD000_0000 + 32'(i));
        tick;
        checks++; if (tx_start_en !== 1'b1) begin errors++; $display("FAIL t4_start1: got %b want 1", tx_start_en); end
        tick;
        // One lone pop frees a slot, then 15 cycles of write+pop keep level at 15.
        tx_req = 1'b1;
        tick;
        checks++; if (tx_data !== 32'hD000_0000) begin errors++; $display("FAIL t4_data[0]: got %h want d0000000", tx_data); end
        for (int i = 0; i < 15; i++) begin
            tx_req = 1'b1; wr_en = 1'b1; wr_data = 32'hE000_0000 + 32'(i);
            tick;
            checks++;
            if (tx_data !== 32'hD000_0000 + 32'(i + 1)) begin
                errors++; $display("FAIL t4_data[%0d]: got %h want %h", i + 1, tx_data, 32'hD000_0000 + 32'(i + 1));
            end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL t4_level[%0d]: full got %b want 0", i, full); end
        end
        tx_req = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL t4_wait_start[%0d]: got %b want 0", i, tx_start_en); end
        end
        wr(32'hE000_000F);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL t4_full16: got %b want 1", full); end
        tick;
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL t4_no_start_before_done: got %b want 0", tx_start_en); end
        done_pulse;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_idle: got %b want 0", busy); end
        tick;
        checks++; if (tx_start_en !== 1'b1) begin errors++; $display("FAIL t4_start2: got %b want 1", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd64) begin errors++; $display("FAIL t4_bytes2: got %0d want 64", tx_byte_num); end
        tick;
        for (int i = 0; i < 16; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'hE000_0000 + 32'(i)) begin
                errors++; $display("FAIL t4_data2[%0d]: got %h want %h", i, tx_data, 32'hE000_0000 + 32'(i));
            end
        end
        tx_req = 1'b0;
        tick; tick;
        done_pulse;
    endtask

    task automatic test_extra_req_early_done;
        bit ok;
        for (int i = 0; i < 16; i++) wr(32'hF000_0000 + 32'(i));
        tick; tick;
        for (int i = 0; i < 5; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'hF000_0000 + 32'(i)) begin
                errors++; $display("FAIL t5_data[%0d]: got %h want %h", i, tx_data, 32'hF000_0000 + 32'(i));
            end
        end
        tx_req = 1'b0;
        done_pulse;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_early_idle: got %b want 0", busy); end
        checks++; if (tx_data !== 32'hF000_0004) begin errors++; $display("FAIL t5_data_hold: got %h want f0000004", tx_data); end
        // The 11 leftover words go out as a timeout-flushed packet.
        wait_start(150, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t5_restart: got no start want start within 150"); end
        checks++; if (tx_byte_num !== 16'd44) begin errors++; $display("FAIL t5_bytes: got %0d want 44", tx_byte_num); end
        tick;
        for (int i = 0; i < 11; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'hF000_0005 + 32'(i)) begin
                errors++; $display("FAIL t5_rest[%0d]: got %h want %h", i, tx_data, 32'hF000_0005 + 32'(i));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tx_req = 1'b1;
            tick;
            checks++; if (tx_data !== 32'hF000_000F) begin errors++; $display("FAIL t5_extra[%0d]: got %h want f000000f", i, tx_data); end
        end
        tx_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_wait_busy: got %b want 1", busy); end
        done_pulse;
        // tx_done while idle must be harmless, and nothing is left to send.
        done_pulse;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_done: got %b want 0", busy); end
        wait_start(150, ok);
        checks++; if (ok) begin errors++; $display("FAIL t5_spurious: got start want none"); end
    endtask

    task automatic test_reset_mid_send;
        bit ok;
        for (int i = 0; i < 16; i++) wr(32'h1000_0000 + 32'(i));
        tick; tick;
        for (int i = 0; i < 8; i++) begin
            tx_req = 1'b1;
            tick;
        end
        tx_req = 1'b0;
        checks++; if (tx_data !== 32'h1000_0007) begin errors++; $display("FAIL t6_pre: got %h want 10000007", tx_data); end
        rst = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy: got %b want 0", busy); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL t6_data: got %h want 0", tx_data); end
        checks++; if (tx_byte_num !== 16'd0) begin errors++; $display("FAIL t6_bytes: got %0d want 0", tx_byte_num); end
        checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL t6_ovf: got %0d want 0", ovf_cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL t6_full: got %b want 0", full); end
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL t6_start: got %b want 0", tx_start_en); end
        rst = 1'b0;
        wait_start(200, ok);
        checks++; if (ok) begin errors++; $display("FAIL t6_spurious: got start want none"); end
        wr(32'h2000_0001);
        wr(32'h2000_0002);
        wait_start(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_restart: got no start want start within 200"); end
        checks++; if (tx_byte_num !== 16'd8) begin errors++; $display("FAIL t6_bytes2: got %0d want 8", tx_byte_num); end
        tick;
        for (int i = 0; i < 2; i++) begin
            tx_req = 1'b1;
            tick;
            checks++;
            if (tx_data !== 32'h2000_0001 + 32'(i)) begin
                errors++; $display("FAIL t6_data2[%0d]: got %h want %h", i, tx_data, 32'h2000_0001 + 32'(i));
            end
        end
        tx_req = 1'b0;
        tick; tick;
        done_pulse;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_idle: got %b want 0", busy); end
    endtask

    initial begin
        tick;
        test_reset;
        test_full_packet;
        test_timeout;
        test_overflow;
        test_concurrent;
        test_extra_req_early_done;
        test_reset_mid_send;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
